// File: rtl/piso_ser.sv
// Parallel-in serial-out shifter with valid/ready handshake on the serial side.
// A new word can be loaded on the edge that transfers the final bit, so back-to-back words leave no gap.
module piso_ser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  input  logic             sready,
  output logic             sout,
  output logic             v,
  output logic             last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Serial outputs depend only on registered state; ready alone looks at sready.
  always_comb begin
    v     = (state_q == SHIFT);
    last  = v && (cnt_q == LAST_CNT);
    sout  = v && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    ready = (state_q == IDLE) || (last && sready);
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = d;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sready) begin
          if (last) begin
            if (load) begin
              shreg_d = d;
              cnt_d   = '0;
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_ser.sv
// Directed bench for piso_ser: one MSB-first and one LSB-first instance, hand-computed bit sequences.
module tb_piso_ser;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] d = '0;
  logic       load = 1'b0;
  logic       sready = 1'b1;
  logic       ready, sout, v, last;
  logic [3:0] d2 = '0;
  logic       load2 = 1'b0;
  logic       sready2 = 1'b1;
  logic       ready2, sout2, v2, last2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_ser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clr(clr), .d(d), .load(load), .ready(ready),
    .sready(sready), .sout(sout), .v(v), .last(last)
  );

  piso_ser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clr(clr), .d(d2), .load(load2), .ready(ready2),
    .sready(sready2), .sout(sout2), .v(v2), .last(last2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_v, input logic e_sout, input logic e_last);
    check({tag, ".v"}, 32'(v), 32'(e_v));
    check({tag, ".sout"}, 32'(sout), 32'(e_sout));
    check({tag, ".last"}, 32'(last), 32'(e_last));
  endtask

  initial begin
    logic [0:3] seq4;
    logic [0:7] seq8;

    // Reset state
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.v2", 32'(v2), 32'd0);

    // Single word 1011, MSB first, sready held high
    seq4 = 4'b1011;
    d = 4'b1011; load = 1'b1; sready = 1'b1;
    step();
    load = 1'b0; d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("word1011.b%0d", i), 1'b1, seq4[i], i == 3);
      step();
    end
    check_outs("word1011.after", 1'b0, 1'b0, 1'b0);
    check("word1011.after.ready", 32'(ready), 32'd1);

    // Backpressure while the 2nd bit is presented; d wiggles meanwhile
    d = 4'b1011; load = 1'b1;
    step();
    load = 1'b0;
    check_outs("stall.b0", 1'b1, 1'b1, 1'b0);
    step();
    sready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 4'(i + 4);
      check_outs($sformatf("stall.hold%0d", i), 1'b1, 1'b0, 1'b0);
      check($sformatf("stall.hold%0d.ready", i), 32'(ready), 32'd0);
      step();
    end
    sready = 1'b1;
    check_outs("stall.b1", 1'b1, 1'b0, 1'b0);
    step();
    check_outs("stall.b2", 1'b1, 1'b1, 1'b0);
    step();
    check_outs("stall.b3", 1'b1, 1'b1, 1'b1);
    step();
    check_outs("stall.after", 1'b0, 1'b0, 1'b0);

    // Back-to-back words 1000 then 0011 with no gap; a busy-time load is ignored
    seq8 = 8'b1000_0011;
    d = 4'b1000; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_outs($sformatf("b2b.b%0d", i), 1'b1, seq8[i], (i == 3) || (i == 7));
      if (i == 1) begin
        d = 4'b1111; load = 1'b1;
        check("b2b.busy.ready", 32'(ready), 32'd0);
      end
      if (i == 3) begin
        d = 4'b0011; load = 1'b1;
        check("b2b.last.ready", 32'(ready), 32'd1);
      end
      step();
      load = 1'b0;
    end
    check_outs("b2b.after", 1'b0, 1'b0, 1'b0);

    // clr mid-word discards it; next load accepted immediately
    d = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    check_outs("clr.b0", 1'b1, 1'b1, 1'b0);
    step();
    clr = 1'b1; load = 1'b1; d = 4'b1111;
    step();
    clr = 1'b0; load = 1'b0;
    check_outs("clr.after", 1'b0, 1'b0, 1'b0);
    check("clr.after.ready", 32'(ready), 32'd1);
    seq4 = 4'b0101;
    d = 4'b0101; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("postclr.b%0d", i), 1'b1, seq4[i], i == 3);
      step();
    end
    check_outs("postclr.after", 1'b0, 1'b0, 1'b0);

    // LSB-first instance: 0010 -> 0,1,0,0 with an ignored mid-word load
    seq4 = 4'b0100;
    d2 = 4'b0010; load2 = 1'b1; sready2 = 1'b1;
    step();
    load2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lsb.b%0d.v", i), 32'(v2), 32'd1);
      check($sformatf("lsb.b%0d.sout", i), 32'(sout2), 32'(seq4[i]));
      check($sformatf("lsb.b%0d.last", i), 32'(last2), 32'(i == 3));
      if (i == 1) begin
        d2 = 4'b1111; load2 = 1'b1;
        check("lsb.busy.ready", 32'(ready2), 32'd0);
      end
      step();
      load2 = 1'b0;
    end
    check("lsb.after.v", 32'(v2), 32'd0);
    check("lsb.after.ready", 32'(ready2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 Parameter WIDTH, default 4: number of bits in each parallel word.
REQ-002 Parameter MSB_FIRST, default 1: serial bit order; 1 sends d[WIDTH-1] first, 0 sends d[0] first.
REQ-003 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-004 clr  input  1  Reset, synchronous and active-high.
REQ-005 d  input  WIDTH  Parallel word to transmit; sampled only on an accepted load.
REQ-006 load  input  1  Parallel-load request; accepted when load=1 and ready=1 at a rising edge.
REQ-007 ready  output  1  Block can accept a load this cycle.
REQ-008 sready  input  1  Downstream accepts the current serial bit this cycle.
REQ-009 sout  output  1  Current serial data bit.
REQ-010 v  output  1  sout holds a valid bit.
REQ-011 last  output  1  Current valid bit is the final bit of its word.

Function
REQ-012 The block SHALL implement two states, IDLE and SHIFT, plus a shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH)) bits, minimum width 1.
REQ-013 In IDLE the outputs SHALL be ready=1, v=0, last=0, sout=0.
REQ-014 In IDLE, an accepted load SHALL capture d, clear the counter and enter SHIFT; v=1 SHALL be presented starting the cycle after the load edge (1-cycle latency).
REQ-015 In SHIFT, v SHALL be 1 and sout SHALL equal the current bit: shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
REQ-016 A bit transfer SHALL occur on an edge where v=1 and sready=1; the transfer shifts the register one position toward the output end and increments the counter.
REQ-017 With v=1 and sready=0, sout, v, last, the counter and the shift register SHALL hold unchanged.
REQ-018 last SHALL be 1 exactly when the state is SHIFT and the counter equals WIDTH-1.
REQ-019 In SHIFT, ready SHALL equal last AND sready, so that a back-to-back load can be accepted only on the edge that transfers the final bit.
REQ-020 On the final-bit transfer with load=1, the block SHALL capture the new d, clear the counter and remain in SHIFT, so v stays 1 with no gap cycle.
REQ-021 On the final-bit transfer with load=0, the block SHALL return to IDLE, and v SHALL be 0 the next cycle.
REQ-022 A load while ready=0 SHALL be ignored, with no effect on state, data or counter.
REQ-023 Changes on d outside an accepted load SHALL have no effect on sout.
REQ-024 sout, v and last SHALL be derived only from registered state, with no combinational path from d or load.

Reset
REQ-025 clr=1 at a rising edge SHALL force IDLE, clear the shift register and counter, and give sout=0, v=0, last=0, ready=1 from the following cycle.
REQ-026 clr SHALL take priority over load and sready on the same edge; any word in flight SHALL be discarded with no further bits emitted.
REQ-027 After clr deasserts, a load SHALL be accepted on the first edge where load=1.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1, sready=1, load d=4'b1011 -> sout=1,0,1,1 on the 4 cycles after load; v=1 on those cycles; last=1 only on the 4th; v=0 and ready=1 on the 5th.
REQ-029 d=4'b1011, sready=0 for 3 cycles while the 2nd bit is presented -> sout=0, v=1, last=0 held for 3 cycles; the remaining bits 1,1 follow once sready=1.
REQ-030 Load 4'b1000, then load=1 with d=4'b0011 during the last bit -> 8 contiguous v=1 cycles with sout=1,0,0,0,0,0,1,1; last=1 on the 4th and 8th cycles.
REQ-031 clr=1 while the 2nd bit of 4'b1111 is presented -> next cycle v=0, sout=0, last=0, ready=1; a following load of 4'b0101 serialises as 0,1,0,1.
REQ-032 MSB_FIRST=0, load d=4'b0010 -> sout=0,1,0,0; load pulsed mid-word with d=4'b1111 -> ignored, and the output sequence is unchanged.
